// File: rtl/mem_walk_checker.sv
// Descending memory walker: reads mem[HI..LO] and checks each word equals its index.
// Define MEM_WALK_FILL_EN to prefill mem[i]=i before the walk.
module mem_walk_checker #(
  parameter int WIDTH = 32,
  parameter int LO = 1,
  parameter int HI = 16,
  parameter int AW = 5,
  localparam int N = HI - LO + 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_rd_data,
`ifdef MEM_WALK_FILL_EN
  output logic             mem_wr_en,
  output logic [WIDTH-1:0] mem_wr_data,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_count,
  output logic [AW-1:0]    first_err_addr,
  output logic [WIDTH-1:0] first_err_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_READ, S_DRAIN, S_DONE
  } state_t;

  localparam logic [AW-1:0] A_HI = AW'(HI);
  localparam logic [AW-1:0] A_LO = AW'(LO);

  state_t           state_q;
  logic             rd_en_q;
  logic [AW-1:0]    addr_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    err_q;
  logic [AW-1:0]    fa_q;
  logic [WIDTH-1:0] fd_q;
  logic             cmp_vld_q;
  logic [AW-1:0]    cmp_addr_q;
`ifdef MEM_WALK_FILL_EN
  logic             wr_en_q;
  logic [WIDTH-1:0] wr_data_q;
`endif

  logic [WIDTH-1:0] exp_d;
  logic             mism_d;
  logic [CW-1:0]    err_d;
  logic [AW-1:0]    addr_dn_d;

  // 4-state compare so X/Z read data is flagged as a mismatch
  assign exp_d     = WIDTH'(cmp_addr_q);
  assign mism_d    = cmp_vld_q && (mem_rd_data !== exp_d);
  assign err_d     = err_q + CW'(1);
  assign addr_dn_d = addr_q - AW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      fa_q       <= '0;
      fd_q       <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
`ifdef MEM_WALK_FILL_EN
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
`endif
    end else begin
      cmp_vld_q  <= rd_en_q;
      cmp_addr_q <= addr_q;
      if (mism_d) begin
        err_q <= err_d;
        if (err_q == '0) begin
          fa_q <= cmp_addr_q;
          fd_q <= mem_rd_data;
        end
      end
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_q  <= '0;
            fa_q   <= '0;
            fd_q   <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            addr_q <= A_HI;
`ifdef MEM_WALK_FILL_EN
            state_q   <= S_FILL;
            wr_en_q   <= 1'b1;
            wr_data_q <= WIDTH'(A_HI);
`else
            state_q <= S_READ;
            rd_en_q <= 1'b1;
`endif
          end
        end
`ifdef MEM_WALK_FILL_EN
        S_FILL: begin
          if (addr_q == A_LO) begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b1;
            addr_q  <= A_HI;
            state_q <= S_READ;
          end else begin
            addr_q    <= addr_dn_d;
            wr_data_q <= WIDTH'(addr_dn_d);
          end
        end
`endif
        S_READ: begin
          if (addr_q == A_LO) begin
            rd_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            addr_q <= addr_dn_d;
          end
        end
        // wait one extra edge so the final compare lands before done
        S_DRAIN: begin
          if (!cmp_vld_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rd_en      = rd_en_q;
  assign mem_addr       = addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = done_q && (err_q == '0);
  assign err_count      = err_q;
  assign first_err_addr = fa_q;
  assign first_err_data = fd_q;
`ifdef MEM_WALK_FILL_EN
  assign mem_wr_en      = wr_en_q;
  assign mem_wr_data    = wr_data_q;
`endif

endmodule

// File: tb/tb_mem_walk_checker.sv
// Scoreboard bench for mem_walk_checker with a behavioural memory
// and a reference model computed directly from the memory image.
module tb_mem_walk_checker;
  localparam int W  = 32;
  localparam int LO = 1;
  localparam int HI = 16;
  localparam int AW = 5;
  localparam int N  = HI - LO + 1;
  localparam int CW = $clog2(N + 1);
`ifdef MEM_WALK_FILL_EN
  localparam int LAT = 2 * N + 2;
`else
  localparam int LAT = N + 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rd_data = '0;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err_addr;
  logic [W-1:0]  first_err_data;
`ifdef MEM_WALK_FILL_EN
  logic          mem_wr_en;
  logic [W-1:0]  mem_wr_data;
`endif

  mem_walk_checker #(.WIDTH(W), .LO(LO), .HI(HI), .AW(AW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
`ifdef MEM_WALK_FILL_EN
    .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data),
`endif
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .first_err_addr(first_err_addr),
    .first_err_data(first_err_data)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
`ifdef MEM_WALK_FILL_EN
    if (mem_wr_en) mem[mem_addr] = mem_wr_data;
`endif
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int           cnt;
    logic [AW-1:0] fa;
    logic [W-1:0] fd;
    int           edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   rd_cnt = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Expected result: scan HI..LO, every word that is not exactly its index
  function automatic exp_t model(input int s);
    exp_t e;
    logic [W-1:0] v;
    e.cnt = 0;
    e.fa = '0;
    e.fd = '0;
    e.edge_n = s + LAT;
    for (int i = HI; i >= LO; i--) begin
`ifdef MEM_WALK_FILL_EN
      v = W'(i);
`else
      v = mem[i];
`endif
      if (v !== W'(i)) begin
        if (e.cnt == 0) begin
          e.fa = AW'(i);
          e.fd = v;
        end
        e.cnt++;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (mem_rd_en) rd_cnt++;
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: got done=1 expected no walk");
        end else begin
          e = exp_q.pop_front();
          chk("done_edge", W'(cyc), W'(e.edge_n));
          chk("err_count", W'(err_count), W'(e.cnt));
          chk("first_err_addr", W'(first_err_addr), W'(e.fa));
          chk("first_err_data", first_err_data, e.fd);
          chk("pass", W'(pass), W'(e.cnt == 0));
          chk("busy_at_done", W'(busy), '0);
          chk("read_count", W'(rd_cnt), W'(N));
        end
        rd_cnt = 0;
      end
      done_prev = done;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no done after %0d cycles expected done", t);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    exp_q.push_back(model(s));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", W'(busy), W'(1));
    chk("done_after_start", W'(done), '0);
    chk("err_cleared", W'(err_count), '0);
    chk("fa_cleared", W'(first_err_addr), '0);
  endtask

  task automatic run_walk(input int ignore_at);
    int s;
    pulse_start(s);
    if (ignore_at > 0) begin
      while (cyc < s + ignore_at - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
  endtask

  task automatic ident_mem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = W'(i);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, W'(busy), '0);
    chk({tag, "_done"}, W'(done), '0);
    chk({tag, "_pass"}, W'(pass), '0);
    chk({tag, "_err"}, W'(err_count), '0);
    chk({tag, "_fa"}, W'(first_err_addr), '0);
    chk({tag, "_fd"}, first_err_data, '0);
    chk({tag, "_rd_en"}, W'(mem_rd_en), '0);
    chk({tag, "_addr"}, W'(mem_addr), '0);
  endtask

  initial begin
    int s;
    int r;
    reset = 1'b1;
    start = 1'b0;
`ifdef MEM_WALK_FILL_EN
    for (int i = 0; i < (1 << AW); i++) mem[i] = 'x;
`else
    ident_mem();
`endif
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_walk(0);
    mem[5] = '0;
    run_walk(0);
    ident_mem();
    mem[16] = 32'hDEAD;
    mem[1] = 32'd7;
    run_walk(0);
    run_walk(10);
    run_walk(0);

    pulse_start(s);
    while (cyc < s + 8) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    exp_q.delete();
    rd_cnt = 0;
    done_prev = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ident_mem();
    run_walk(0);

    for (int k = 0; k < 10; k++) begin
      for (int i = LO; i <= HI; i++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) mem[i] = $urandom;
        else if (r == 1) mem[i] = 'x;
        else if (r == 2) mem[i] = W'(i) ^ (W'(1) << $urandom_range(0, W - 1));
        else mem[i] = W'(i);
      end
      run_walk((k % 3 == 0) ? int'($urandom_range(2, 14)) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
